// File: rtl/uart_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_pkg
// Shared definitions for the memory-mapped UART transmit controller:
//   - sequencer state encoding
//   - register offsets relative to BASE_ADDR
//   - status and control register bit positions
//   - status byte packing helper
// -----------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Register offsets from BASE_ADDR
    localparam int unsigned REG_DATA = 0;
    localparam int unsigned REG_CTRL = 1;

    // Status byte bit positions
    localparam int unsigned ST_FULL   = 0;
    localparam int unsigned ST_EMPTY  = 1;
    localparam int unsigned ST_OVF    = 2;
    localparam int unsigned ST_ACTIVE = 3;

    // Control register bit positions
    localparam int unsigned CTL_CLR_OVF = 0;
    localparam int unsigned CTL_FLUSH   = 1;

    // Bit 0 stays "full" so legacy firmware polling it as "busy" keeps working.
    function automatic logic [7:0] pack_status(
        input logic full,
        input logic empty,
        input logic ovf,
        input logic active
    );
        logic [7:0] s;
        s            = '0;
        s[ST_FULL]   = full;
        s[ST_EMPTY]  = empty;
        s[ST_OVF]    = ovf;
        s[ST_ACTIVE] = active;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock byte FIFO with first-word-fall-through head output.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_push, i_din   - write request and data (ignored while full)
//   i_pop           - read request (ignored while empty)
//   i_flush         - empty the FIFO; wins over push and pop
//   o_dout          - current head entry (combinational)
//   o_count         - number of stored entries (0..DEPTH)
//   o_full, o_empty - occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    // Fullness is judged on the start-of-cycle count: a same-cycle pop does
    // not make room for a push.
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Memory-mapped UART transmit controller. CPU writes to BASE_ADDR are queued
// in a byte FIFO; a sequencer drains the FIFO into the transmitter using the
// wr_en / tx_busy handshake.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   m_addr        - CPU bus address (BASE_ADDR data/status, BASE_ADDR+1 control)
//   m_wr_data     - CPU write data
//   m_wr, m_rd    - write / read strobes, qualified by m_en
//   m_en          - bus enable
//   rd_data       - status byte (combinational, zero when not addressed)
//   rd_hit        - status read decode for the SoC read mux
//   tx_din        - byte presented to the transmitter (registered)
//   tx_wr_en      - one-cycle load pulse to the transmitter (registered)
//   tx_busy       - transmitter busy
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter logic [10:0] BASE_ADDR    = 11'd101,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] m_addr,
    input  logic [7:0]  m_wr_data,
    input  logic        m_wr,
    input  logic        m_rd,
    input  logic        m_en,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic [7:0]  tx_din,
    output logic        tx_wr_en,
    input  logic        tx_busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    localparam logic [10:0] DATA_ADDR = BASE_ADDR + 11'(REG_DATA);
    localparam logic [10:0] CTRL_ADDR = BASE_ADDR + 11'(REG_CTRL);

    tx_state_t     r_state;
    tx_state_t     w_next_state;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_overflow;
    logic [7:0]    r_tx_din;
    logic          r_tx_wr_en;

    logic          w_data_wr;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_ovf;
    logic          w_load;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_active;

    // ---------------------------------------------------------------- decode
    assign w_data_wr = m_en & m_wr & (m_addr == DATA_ADDR);
    assign w_ctrl_wr = m_en & m_wr & (m_addr == CTRL_ADDR);
    assign w_flush   = w_ctrl_wr & m_wr_data[CTL_FLUSH];
    assign w_clr_ovf = w_ctrl_wr & m_wr_data[CTL_CLR_OVF];
    assign rd_hit    = m_en & m_rd & (m_addr == DATA_ADDR);

    // ------------------------------------------------------------------ FIFO
    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_data_wr),
        .i_pop   (w_load),
        .i_flush (w_flush),
        .i_din   (m_wr_data),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ------------------------------------------------------------ sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A flush in the same cycle as an IDLE pop wins, so the head byte is
    // discarded rather than loaded.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !tx_busy && !w_flush) begin
                    w_next_state = LOAD;
                    w_load       = 1'b1;
                end
            end
            LOAD: begin
                w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next_state = WAIT_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_next_state = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Counts WAIT_BUSY cycles without tx_busy; cleared while in LOAD.
    always_ff @(posedge clk) begin
        if (reset || r_state == LOAD) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_BUSY && !tx_busy) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // tx_wr_en is registered from the IDLE->LOAD decision, so it is high
    // exactly during the LOAD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_din   <= '0;
            r_tx_wr_en <= 1'b0;
        end else begin
            r_tx_wr_en <= w_load;
            if (w_load) begin
                r_tx_din <= w_head;
            end
        end
    end

    assign tx_din   = r_tx_din;
    assign tx_wr_en = r_tx_wr_en;

    // ------------------------------------------------------- status/control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_data_wr && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_active = (r_state != IDLE) | tx_busy;
    assign rd_data  = rd_hit ? pack_status(w_full, w_empty, r_overflow, w_active) : '0;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] m_addr = '0;
    logic [7:0]  m_wr_data = '0;
    logic        m_wr = 1'b0;
    logic        m_rd = 1'b0;
    logic        m_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic [7:0]  tx_din;
    logic        tx_wr_en;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // transmitter model and pulse monitor
    logic       model_en   = 1'b0;
    logic       force_busy = 1'b0;
    int         busy_len   = 20;
    int         busy_cnt   = 0;
    logic       seen_wr    = 1'b0;
    logic       prev_wr    = 1'b0;
    int         dbl_err    = 0;
    int         busy_err   = 0;
    logic [7:0] pulse_q[$];
    int         pulse_cyc[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .BASE_ADDR    (11'd101),
        .DEPTH        (16),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_wr      (m_wr),
        .m_rd      (m_rd),
        .m_en      (m_en),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .tx_busy   (tx_busy)
    );

    assign tx_busy = force_busy | (busy_cnt != 0);

    always @(posedge clk) cyc++;

    // Busy rises one cycle after the load cycle and stays for busy_len cycles.
    always @(negedge clk) begin
        if (tx_wr_en === 1'b1) begin
            pulse_q.push_back(tx_din);
            pulse_cyc.push_back(cyc);
            if (prev_wr) dbl_err++;
            if (tx_busy) busy_err++;
        end
        prev_wr = (tx_wr_en === 1'b1);
        if (busy_cnt != 0) busy_cnt--;
        if (seen_wr && model_en) busy_cnt = busy_len;
        seen_wr = (tx_wr_en === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [10:0] a, input logic [7:0] d);
        m_en = 1'b1; m_wr = 1'b1; m_addr = a; m_wr_data = d;
        tick();
        m_en = 1'b0; m_wr = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] s, output logic h);
        m_en = 1'b1; m_rd = 1'b1; m_addr = 11'd101;
        #1;
        s = rd_data;
        h = rd_hit;
        m_en = 1'b0; m_rd = 1'b0;
    endtask

    task automatic clear_log();
        pulse_q.delete();
        pulse_cyc.delete();
        dbl_err  = 0;
        busy_err = 0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (pulse_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        logic h;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++;
        if (tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", tx_wr_en); end
        n_checks++;
        if (tx_din !== 8'h00) begin n_fail++; $display("FAIL reset_tx_din: got %02h expected 00", tx_din); end
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %02h expected 02", s); end
        n_checks++;
        if (h !== 1'b1) begin n_fail++; $display("FAIL reset_rd_hit: got %b expected 1", h); end
        m_en = 1'b1; m_rd = 1'b1; m_addr = 11'd102;
        #1;
        n_checks++;
        if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL rd_hit_ctrl_addr: got %b expected 0", rd_hit); end
        m_en = 1'b0; m_rd = 1'b0;
        #1;
        n_checks++;
        if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL rd_hit_idle_bus: got %b expected 0", rd_hit); end
    endtask

    task automatic test_single_byte();
        logic [7:0] s;
        logic h;
        int c0;
        clear_log();
        model_en = 1'b1; busy_len = 20;
        bus_write(11'd101, 8'h41);
        c0 = cyc;
        read_status(s, h);
        n_checks++;
        if (s !== 8'h00) begin n_fail++; $display("FAIL single_status_queued: got %02h expected 00", s); end
        tick();
        n_checks++;
        if (tx_wr_en !== 1'b1 || tx_din !== 8'h41) begin
            n_fail++; $display("FAIL single_load: got wr_en=%b din=%02h expected 1/41", tx_wr_en, tx_din);
        end
        n_checks++;
        if (pulse_cyc.size() != 1 || pulse_cyc[0] != c0 + 1) begin
            n_fail++; $display("FAIL single_latency: got %0d pulses first at +%0d expected 1 at +1",
                               pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] - c0 : -1);
        end
        tick();
        n_checks++;
        if (tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", tx_wr_en); end
        tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h0A) begin n_fail++; $display("FAIL single_status_busy: got %02h expected 0a", s); end
        repeat (25) tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL single_status_done: got %02h expected 02", s); end
        n_checks++;
        if (pulse_q.size() != 1 || tx_din !== 8'h41) begin
            n_fail++; $display("FAIL single_pulse_count: got %0d pulses din=%02h expected 1/41", pulse_q.size(), tx_din);
        end
    endtask

    task automatic test_burst();
        logic [7:0] s;
        logic h;
        int bad;
        clear_log();
        model_en = 1'b1; busy_len = 3;
        for (int i = 0; i < 16; i++) bus_write(11'd101, 8'(i));
        // pops at write edges +1, +7, +13 leave 13 queued while busy
        read_status(s, h);
        n_checks++;
        if (s !== 8'h08) begin n_fail++; $display("FAIL burst_status_after_writes: got %02h expected 08", s); end
        wait_pulses(16, 300);
        n_checks++;
        if (pulse_q.size() != 16) begin n_fail++; $display("FAIL burst_pulse_count: got %0d expected 16", pulse_q.size()); end
        bad = 0;
        for (int i = 0; i < 16 && i < pulse_q.size(); i++) begin
            if (pulse_q[i] !== 8'(i)) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL burst_order: got %0d wrong bytes expected 0", bad); end
        bad = 0;
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            if (pulse_cyc[i] - pulse_cyc[i-1] != 6) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL burst_pacing: got %0d gaps not 6 expected 0", bad); end
        n_checks++;
        if (dbl_err != 0 || busy_err != 0) begin
            n_fail++; $display("FAIL burst_handshake: got double=%0d load_while_busy=%0d expected 0/0", dbl_err, busy_err);
        end
        repeat (10) tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL burst_drained: got %02h expected 02", s); end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic h;
        int bad;
        force_busy = 1'b1;
        model_en = 1'b1; busy_len = 3;
        tick();
        clear_log();
        for (int i = 0; i < 16; i++) bus_write(11'd101, 8'h20 + 8'(i));
        read_status(s, h);
        n_checks++;
        if (s !== 8'h09) begin n_fail++; $display("FAIL ovf_full: got %02h expected 09", s); end
        bus_write(11'd101, 8'h30);
        read_status(s, h);
        n_checks++;
        if (s !== 8'h0D) begin n_fail++; $display("FAIL ovf_set: got %02h expected 0d", s); end
        bus_write(11'd102, 8'h01);
        read_status(s, h);
        n_checks++;
        if (s !== 8'h09) begin n_fail++; $display("FAIL ovf_clear: got %02h expected 09", s); end
        force_busy = 1'b0;
        wait_pulses(16, 300);
        repeat (10) tick();
        n_checks++;
        if (pulse_q.size() != 16) begin n_fail++; $display("FAIL ovf_pulse_count: got %0d expected 16", pulse_q.size()); end
        bad = 0;
        for (int i = 0; i < 16 && i < pulse_q.size(); i++) begin
            if (pulse_q[i] !== 8'h20 + 8'(i)) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL ovf_contents: got %0d wrong bytes expected 0", bad); end
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL ovf_drained: got %02h expected 02", s); end
    endtask

    task automatic test_flush();
        logic [7:0] s;
        logic h;
        force_busy = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 5; i++) bus_write(11'd101, 8'h50 + 8'(i));
        read_status(s, h);
        n_checks++;
        if (s !== 8'h08) begin n_fail++; $display("FAIL flush_queued: got %02h expected 08", s); end
        bus_write(11'd102, 8'h02);
        read_status(s, h);
        n_checks++;
        if (s !== 8'h0A) begin n_fail++; $display("FAIL flush_empty_active: got %02h expected 0a", s); end
        force_busy = 1'b0;
        repeat (10) tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL flush_idle: got %02h expected 02", s); end
        n_checks++;
        if (pulse_q.size() != 0) begin n_fail++; $display("FAIL flush_no_loads: got %0d pulses expected 0", pulse_q.size()); end
    endtask

    task automatic test_timeout();
        logic [7:0] s;
        logic h;
        clear_log();
        model_en = 1'b0;
        bus_write(11'd101, 8'hA5);
        bus_write(11'd101, 8'h5A);
        n_checks++;
        if (tx_wr_en !== 1'b1 || tx_din !== 8'hA5) begin
            n_fail++; $display("FAIL tmo_first_load: got wr_en=%b din=%02h expected 1/a5", tx_wr_en, tx_din);
        end
        repeat (4) tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h08) begin n_fail++; $display("FAIL tmo_waiting: got %02h expected 08", s); end
        tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h00) begin n_fail++; $display("FAIL tmo_back_to_idle: got %02h expected 00", s); end
        tick();
        n_checks++;
        if (tx_wr_en !== 1'b1 || tx_din !== 8'h5A) begin
            n_fail++; $display("FAIL tmo_next_load: got wr_en=%b din=%02h expected 1/5a", tx_wr_en, tx_din);
        end
        n_checks++;
        if (pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != 6) begin
            n_fail++; $display("FAIL tmo_spacing: got %0d pulses gap %0d expected 2 gap 6", pulse_cyc.size(),
                               (pulse_cyc.size() > 1) ? pulse_cyc[1] - pulse_cyc[0] : -1);
        end
        repeat (8) tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL tmo_final_idle: got %02h expected 02", s); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] s;
        logic h;
        clear_log();
        model_en = 1'b1; busy_len = 20;
        for (int i = 0; i < 4; i++) bus_write(11'd101, 8'h61 + 8'(i));
        read_status(s, h);
        n_checks++;
        if (s !== 8'h08) begin n_fail++; $display("FAIL rst_pre_status: got %02h expected 08", s); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (tx_wr_en !== 1'b0 || tx_din !== 8'h00) begin
            n_fail++; $display("FAIL rst_outputs: got wr_en=%b din=%02h expected 0/00", tx_wr_en, tx_din);
        end
        read_status(s, h);
        n_checks++;
        if (s !== 8'h0A) begin n_fail++; $display("FAIL rst_status_busy: got %02h expected 0a", s); end
        repeat (30) tick();
        read_status(s, h);
        n_checks++;
        if (s !== 8'h02) begin n_fail++; $display("FAIL rst_status_idle: got %02h expected 02", s); end
        n_checks++;
        if (pulse_q.size() != 1 || tx_din !== 8'h00) begin
            n_fail++; $display("FAIL rst_no_more_loads: got %0d pulses din=%02h expected 1/00", pulse_q.size(), tx_din);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_flush();
        test_timeout();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
